// File: rtl/inst_fetch.sv
// Instruction-fetch stage: one Wishbone classic read per PC, result held in the IF/ID register.
// Optional FETCH_MISALIGN_CHECK_EN turns a misaligned PC into a flagged bubble instead of a bus read.
module inst_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   pc_in,
  input  logic [1:0]              stall_and_flush,
  output logic                    pc_advance,
  output logic                    fetch_busy,
  output logic [DATA_WIDTH-1:0]   inst_out,
  output logic [ADDR_WIDTH-1:0]   pc_out,
  output logic                    inst_valid,
  output logic                    misalign,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]            state_r;
  logic [ADDR_WIDTH-1:0] req_pc_r;
  logic                  flush_s;
  logic                  launch_s;
  logic                  misalign_s;
  logic [ADDR_WIDTH-1:0] fetch_adr_s;

  // Code 11 is decoded as FLUSH, so bit 1 alone selects flush.
  assign flush_s  = stall_and_flush[1];
  assign launch_s = ((state_r == S_IDLE) || (state_r == S_DONE)) &&
                    (stall_and_flush == 2'b00);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_s  = (pc_in[1:0] != 2'b00);
  assign fetch_adr_s = pc_in;
`else
  assign misalign_s  = 1'b0;
  assign fetch_adr_s = {pc_in[ADDR_WIDTH-1:2], 2'b00};
`endif

  assign wb_stb_o = wb_cyc_o;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = {(DATA_WIDTH/8){1'b1}};

  // Fetch FSM with all stage outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      req_pc_r   <= '0;
      wb_cyc_o   <= 1'b0;
      wb_adr_o   <= '0;
      inst_out   <= NOP_INST;
      pc_out     <= '0;
      inst_valid <= 1'b0;
      misalign   <= 1'b0;
      pc_advance <= 1'b0;
      fetch_busy <= 1'b0;
    end else begin
      pc_advance <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE: begin
          if (launch_s) begin
            pc_advance <= 1'b1;
            req_pc_r   <= pc_in;
            inst_out   <= NOP_INST;
            if (misalign_s) begin
              // Misaligned PC: no bus cycle, present a flagged bubble instead.
              state_r    <= S_DONE;
              pc_out     <= pc_in;
              inst_valid <= 1'b1;
              misalign   <= 1'b1;
              fetch_busy <= 1'b0;
            end else begin
              state_r    <= S_BUSY;
              wb_cyc_o   <= 1'b1;
              wb_adr_o   <= fetch_adr_s;
              inst_valid <= 1'b0;
              misalign   <= 1'b0;
              fetch_busy <= 1'b1;
            end
          end else if (flush_s && (state_r == S_DONE)) begin
            state_r    <= S_IDLE;
            inst_out   <= NOP_INST;
            inst_valid <= 1'b0;
            misalign   <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        S_BUSY: begin
          if (wb_ack_i) begin
            wb_cyc_o   <= 1'b0;
            fetch_busy <= 1'b0;
            if (flush_s) begin
              state_r <= S_IDLE;
            end else begin
              state_r    <= S_DONE;
              inst_out   <= wb_dat_i;
              pc_out     <= req_pc_r;
              inst_valid <= 1'b1;
            end
          end else if (flush_s) begin
            // A Wishbone cycle is never abandoned; drain it and drop the data.
            state_r <= S_DISCARD;
          end else begin
            state_r <= S_BUSY;
          end
        end
        S_DISCARD: begin
          if (wb_ack_i) begin
            state_r    <= S_IDLE;
            wb_cyc_o   <= 1'b0;
            fetch_busy <= 1'b0;
          end else begin
            state_r <= S_DISCARD;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          wb_cyc_o   <= 1'b0;
          inst_out   <= NOP_INST;
          inst_valid <= 1'b0;
          misalign   <= 1'b0;
          fetch_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: expected instructions go into a scoreboard queue,
// a monitor pops them whenever inst_valid rises; control-signal checks are inline.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic [1:0]  stall_and_flush;
  logic        pc_advance, fetch_busy, inst_valid, misalign;
  logic [31:0] inst_out, pc_out;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_i;
  logic        wb_ack_i;

  int n_pass  = 0;
  int n_total = 0;
  int adv_cnt = 0;
  logic prev_valid = 1'b0;
  logic [64:0] exp_q[$];

  inst_fetch dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .stall_and_flush(stall_and_flush),
    .pc_advance(pc_advance), .fetch_busy(fetch_busy), .inst_out(inst_out),
    .pc_out(pc_out), .inst_valid(inst_valid), .misalign(misalign),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: each new valid instruction must match the queue head.
  always @(negedge clk) begin
    logic [64:0] act;
    logic [64:0] exp;
    if (pc_advance === 1'b1) adv_cnt++;
    if (inst_valid === 1'b1 && prev_valid !== 1'b1) begin
      act = {misalign, inst_out, pc_out};
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output: got %h expected none", act);
      end else begin
        exp = exp_q.pop_front();
        if (act === exp) n_pass++;
        else $display("FAIL scoreboard: got %h expected %h", act, exp);
      end
    end
    prev_valid = inst_valid;
  end

  initial begin
    reset = 1'b1; pc_in = 32'h0; stall_and_flush = 2'b01;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0;
    step(); step();
    chk("rst_cyc", {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
    chk("rst_adr", {32'd0, wb_adr_o}, 64'd0);
    chk("rst_inst", {32'd0, inst_out}, {32'd0, NOP});
    chk("rst_pc", {32'd0, pc_out}, 64'd0);
    chk("rst_flags", {60'd0, inst_valid, misalign, pc_advance, fetch_busy}, 64'd0);
    chk("rst_const", {59'd0, wb_we_o, wb_sel_o}, {59'd0, 1'b0, 4'hF});
    reset = 1'b0;
    step();

    // Basic fetch, slave acks one cycle after the strobe cycle
    pc_in = 32'h8000_0000; stall_and_flush = 2'b00;
    exp_q.push_back({1'b0, 32'h0010_0093, 32'h8000_0000});
    step();
    stall_and_flush = 2'b01;
    chk("t1_cyc", {62'd0, wb_cyc_o, wb_stb_o}, 64'd3);
    chk("t1_adr", {32'd0, wb_adr_o}, 64'h8000_0000);
    chk("t1_adv", {62'd0, pc_advance, fetch_busy}, 64'd3);
    step();
    chk("t1_adv_once", {63'd0, pc_advance}, 64'd0);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0010_0093;
    step();
    wb_ack_i = 1'b0;
    chk("t1_done", {61'd0, wb_cyc_o, inst_valid, fetch_busy}, 64'd2);
    chk("t1_inst", {inst_out, pc_out}, {32'h0010_0093, 32'h8000_0000});
    chk("t1_adv_cnt", adv_cnt, 64'd1);

    // Stall hold in DONE
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold", {inst_out, pc_out}, {32'h0010_0093, 32'h8000_0000});
      chk("t2_ctl", {61'd0, inst_valid, wb_cyc_o, pc_advance}, 64'd4);
    end

    // Flush in the second of four wait cycles
    pc_in = 32'h8000_0004; stall_and_flush = 2'b00;
    step();
    stall_and_flush = 2'b01;
    chk("t3_launch", {wb_adr_o, inst_out}, {32'h8000_0004, NOP});
    chk("t3_valid", {62'd0, inst_valid, wb_cyc_o}, 64'd1);
    step();
    stall_and_flush = 2'b10;
    step();
    stall_and_flush = 2'b01;
    for (int i = 0; i < 2; i++) begin
      chk("t3_hold_cyc", {61'd0, wb_cyc_o, inst_valid, fetch_busy}, 64'd5);
      chk("t3_adr_stable", {32'd0, wb_adr_o}, 64'h8000_0004);
      step();
    end
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    step();
    wb_ack_i = 1'b0;
    chk("t3_end", {61'd0, wb_cyc_o, inst_valid, fetch_busy}, 64'd0);
    chk("t3_inst", {32'd0, inst_out}, {32'd0, NOP});
    step();
    chk("t3_idle", {62'd0, wb_cyc_o, pc_advance}, 64'd0);

    // Ack and flush together in BUSY
    pc_in = 32'h8000_0008; stall_and_flush = 2'b00;
    step();
    wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678; stall_and_flush = 2'b10;
    step();
    wb_ack_i = 1'b0; stall_and_flush = 2'b01;
    chk("t4_drop", {61'd0, wb_cyc_o, inst_valid, fetch_busy}, 64'd0);
    chk("t4_inst", {32'd0, inst_out}, {32'd0, NOP});
    step();
    chk("t4_idle", {62'd0, wb_cyc_o, pc_advance}, 64'd0);

    // Reset during BUSY, late ack ignored
    pc_in = 32'h8000_000C; stall_and_flush = 2'b00;
    step();
    stall_and_flush = 2'b01;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_rst", {61'd0, wb_cyc_o, inst_valid, fetch_busy}, 64'd0);
    chk("t5_adr", {32'd0, wb_adr_o}, 64'd0);
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
    step();
    wb_ack_i = 1'b0;
    chk("t5_late_ack", {62'd0, wb_cyc_o, inst_valid}, 64'd0);

    // Back-to-back zero-wait fetches
    pc_in = 32'h8000_0010; stall_and_flush = 2'b00;
    exp_q.push_back({1'b0, 32'h0000_0001, 32'h8000_0010});
    exp_q.push_back({1'b0, 32'h0000_0002, 32'h8000_0014});
    step();
    wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0001; pc_in = 32'h8000_0014;
    step();
    wb_ack_i = 1'b0;
    chk("t6_first", {31'd0, inst_valid, pc_out}, {31'd0, 1'b1, 32'h8000_0010});
    step();
    chk("t6_relaunch", {30'd0, wb_cyc_o, pc_advance, wb_adr_o}, {30'd0, 2'b11, 32'h8000_0014});
    chk("t6_bubble", {63'd0, inst_valid}, 64'd0);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0002; stall_and_flush = 2'b01;
    step();
    wb_ack_i = 1'b0;
    chk("t6_second", {inst_out, pc_out}, {32'h0000_0002, 32'h8000_0014});

    // Misaligned PC
    stall_and_flush = 2'b10;
    step();
    chk("t7_flush", {62'd0, inst_valid, misalign}, 64'd0);
    pc_in = 32'h8000_0002; stall_and_flush = 2'b00;
`ifdef FETCH_MISALIGN_CHECK_EN
    exp_q.push_back({1'b1, NOP, 32'h8000_0002});
    step();
    stall_and_flush = 2'b01;
    chk("t7_nobus", {60'd0, wb_cyc_o, pc_advance, misalign, inst_valid}, 64'd7);
    step();
    chk("t7_nobus2", {63'd0, wb_cyc_o}, 64'd0);
    stall_and_flush = 2'b10;
    step();
    chk("t7_clear", {62'd0, misalign, inst_valid}, 64'd0);
`else
    exp_q.push_back({1'b0, 32'h0000_0003, 32'h8000_0002});
    step();
    stall_and_flush = 2'b01;
    chk("t7_adr", {31'd0, wb_cyc_o, wb_adr_o}, {31'd0, 1'b1, 32'h8000_0000});
    chk("t7_nomis", {63'd0, misalign}, 64'd0);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0003;
    step();
    wb_ack_i = 1'b0;
    chk("t7_done", {62'd0, inst_valid, misalign}, 64'd2);
`endif
    step();
    chk("end_adv_cnt", adv_cnt, 64'd7);
    chk("end_queue_empty", exp_q.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage sitting directly downstream of the PC register in the 5-stage core. Each cycle the pipeline advances, it samples the current PC and issues a single Wishbone classic read for the instruction word. It holds the returned word and its PC in the IF/ID output register until the decode stage takes it. It obeys the same `stall_and_flush` control encoding as the PC register and reports when it is busy, so the hazard unit can freeze the PC.

## Interface

Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.

Parameters:
- `ADDR_WIDTH`, 32, address and PC width
- `DATA_WIDTH`, 32, instruction / bus data width
- `NOP_INST`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`) driven when no valid instruction is held

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `pc_in`  in  ADDR_WIDTH  current PC from the PC register
- `stall_and_flush`  in  2  00 FETCH, 01 STALL, 10 FLUSH, 11 treated as FLUSH
- `pc_advance`  out  1  one-cycle pulse: `pc_in` was sampled this edge, PC register may update
- `fetch_busy`  out  1  high while a bus read is outstanding (BUSY or DISCARD)
- `inst_out`  out  DATA_WIDTH  fetched instruction to ID
- `pc_out`  out  ADDR_WIDTH  PC of `inst_out`
- `inst_valid`  out  1  `inst_out` / `pc_out` hold a real instruction
- `misalign`  out  1  `pc_out` was misaligned (see Configuration)
- `wb_cyc_o`, `wb_stb_o`  out  1  Wishbone cycle / strobe, always equal
- `wb_we_o`  out  1  constant 0
- `wb_sel_o`  out  DATA_WIDTH/8  constant all-ones
- `wb_adr_o`  out  ADDR_WIDTH  read address
- `wb_dat_i`  in  DATA_WIDTH  read data
- `wb_ack_i`  in  1  transfer acknowledge

## Operation

- FSM states: IDLE, BUSY, DONE, DISCARD. All outputs are registered.
- Launch condition: state is IDLE or DONE and `stall_and_flush`==00.
- On launch:
  - register `pc_in` into `req_pc`
  - drive `wb_adr_o`=`pc_in`
  - raise `wb_cyc_o`/`wb_stb_o`
  - pulse `pc_advance`
  - clear `inst_valid`, drive `inst_out`=`NOP_INST`
  - go to BUSY
- IDLE: with STALL or FLUSH, remain in IDLE.
- BUSY: wait for `wb_ack_i`. STALL is ignored; the bus transfer continues.
  - ack without flush: capture `wb_dat_i` into `inst_out`, set `pc_out`=`req_pc` and `inst_valid`=1, drop cyc/stb, go to DONE.
  - flush without ack: go to DISCARD. cyc/stb stay asserted; a Wishbone cycle is never abandoned.
  - ack and flush in the same cycle: data dropped, cyc/stb dropped, go to IDLE.
- DISCARD: wait for ack. On ack, drop cyc/stb, discard data, go to IDLE. Further flushes have no extra effect.
- DONE: behaviour depends on `stall_and_flush`.
  - STALL: hold `inst_out`, `pc_out` and `inst_valid` unchanged.
  - FLUSH: `inst_out`=`NOP_INST`, `inst_valid`=0, go to IDLE.
  - FETCH: launch the next fetch (same edge).
- `fetch_busy` = state is BUSY or DISCARD. The hazard unit ORs it into the PC stall.

## Timing

- Reset values:
  - state IDLE
  - `wb_cyc_o`=`wb_stb_o`=0, `wb_adr_o`=0
  - `inst_out`=`NOP_INST`, `pc_out`=0
  - `inst_valid`=0, `misalign`=0, `pc_advance`=0, `fetch_busy`=0
- Reset asserted mid-transaction: cyc/stb are 0 from the next edge. A late ack after reset is ignored.
- Launch at edge N: cyc/stb are high in cycle N+1.
- Ack sampled at edge M: `inst_valid`=1 from M+1.
- Zero-wait slave (ack in first strobe cycle): PC sample to `inst_valid` is 2 cycles. Back-to-back throughput is one instruction per 2 cycles.
- `pc_advance` is high exactly one cycle after each launch edge and never in any other cycle.
- `wb_adr_o` is stable for the whole BUSY/DISCARD period.

## Configuration

- `FETCH_MISALIGN_CHECK_EN` defined:
  - At launch with `pc_in[1:0]`≠0, no bus cycle is issued and `pc_advance` still pulses.
  - Next state is DONE with `inst_out`=`NOP_INST`, `pc_out`=`pc_in`, `inst_valid`=1, `misalign`=1.
  - `misalign` clears on the next launch or on flush.
- Not defined:
  - `wb_adr_o` = {`pc_in`[ADDR_WIDTH-1:2], 2'b00}.
  - `misalign` is tied 0.

## Test plan

- Basic fetch: reset, then `pc_in`=0x8000_0000, FETCH; slave acks 1 cycle after strobe with 0x0010_0093 -> `wb_adr_o`=0x8000_0000, then `inst_out`=0x0010_0093, `pc_out`=0x8000_0000, `inst_valid`=1; one `pc_advance` pulse.
- Stall hold: after a DONE holding 0x0010_0093, apply STALL for 5 cycles -> outputs unchanged, no cyc/stb, no `pc_advance`.
- Flush mid-read: flush in the second of 4 wait cycles with slave data 0xDEAD_BEEF -> cyc/stb stay high until ack, `inst_valid` stays 0, `inst_out`=0x0000_0013, then IDLE.
- Simultaneous ack and flush in BUSY -> `inst_valid`=0, data dropped, cyc/stb low next cycle, state IDLE.
- Reset during BUSY -> cyc/stb=0 and `inst_valid`=0 next cycle; an ack arriving afterwards is ignored.
- With `FETCH_MISALIGN_CHECK_EN`: `pc_in`=0x8000_0002 -> no cyc/stb; `misalign`=1, `inst_valid`=1, `inst_out`=0x0000_0013. Without the macro: `wb_adr_o`=0x8000_0000.
